// File: rtl/adder_pipelined.sv
// rtl/adder_pipelined.sv - chunked pipelined add/subtract with streaming valid/ready handshake
// Optional: define ADDER_PIPELINED_SATURATE_EN to clamp overflowing results to the signed limit.
module adder_pipelined #(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         overflow
);

  localparam int W = N / STAGES;

  if (STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_cfg
    $error("adder_pipelined: N must be a multiple of STAGES and 1 <= STAGES <= N");
  end

  logic adv;
  logic take;

  // Whole pipe moves in lockstep: it only stalls when a finished result is not taken.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !rst;
  assign take     = in_valid && in_ready;

  // Stage inputs (comb) and stage registers; operands are kept right-aligned so
  // every stage adds the low W bits, and sum chunks are shifted in from the top.
  logic [N-1:0] a_in  [STAGES];
  logic [N-1:0] b_in  [STAGES];
  logic [N-1:0] s_in  [STAGES];
  logic         cy_in [STAGES];
  logic         v_in  [STAGES];

  logic [N-1:0] a_q   [STAGES];
  logic [N-1:0] b_q   [STAGES];
  logic [N-1:0] s_q   [STAGES];
  logic         cy_q  [STAGES];
  logic         v_q   [STAGES];
  logic         ovf_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [W:0]   add_w;
    logic [N-1:0] s_nxt;
    logic [N-1:0] s_store;

    if (k == 0) begin : g_entry
      assign a_in[k]  = a;
      assign b_in[k]  = sub ? ~b : b;
      assign cy_in[k] = sub ? ~c_in : c_in;
      assign s_in[k]  = '0;
      assign v_in[k]  = take;
    end else begin : g_link
      assign a_in[k]  = a_q[k-1];
      assign b_in[k]  = b_q[k-1];
      assign cy_in[k] = cy_q[k-1];
      assign s_in[k]  = s_q[k-1];
      assign v_in[k]  = v_q[k-1];
    end

    assign add_w = {1'b0, a_in[k][W-1:0]} + {1'b0, b_in[k][W-1:0]} + {{W{1'b0}}, cy_in[k]};
    assign s_nxt = (s_in[k] >> W) | (N'(add_w[W-1:0]) << (N - W));

    if (k == STAGES - 1) begin : g_last
      logic ovf_nxt;

      // Carry into the MSB is recovered as a ^ b ^ s at that bit.
      assign ovf_nxt = a_in[k][W-1] ^ b_in[k][W-1] ^ add_w[W-1] ^ add_w[W];

`ifdef ADDER_PIPELINED_SATURATE_EN
      assign s_store = !ovf_nxt   ? s_nxt :
                       s_nxt[N-1] ? {1'b0, {(N-1){1'b1}}} :
                                    {1'b1, {(N-1){1'b0}}};
`else
      assign s_store = s_nxt;
`endif

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= ovf_nxt;
        end
      end
    end else begin : g_mid
      assign s_store = s_nxt;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q[k] <= '0;
          b_q[k] <= '0;
        end else if (adv) begin
          a_q[k] <= a_in[k] >> W;
          b_q[k] <= b_in[k] >> W;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q[k]  <= 1'b0;
        s_q[k]  <= '0;
        cy_q[k] <= 1'b0;
      end else if (adv) begin
        v_q[k]  <= v_in[k];
        s_q[k]  <= s_store;
        cy_q[k] <= add_w[W];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign c_out     = cy_q[STAGES-1];
  assign overflow  = ovf_q;

endmodule
